// File: rtl/unified_mem_port.sv
// unified_mem_port
//   Shares one fixed-latency external memory port between the instruction
//   fetch channel and the data load/store channel. A winning request is
//   latched in IDLE, held on the bus for LATENCY cycles (ACCESS), and
//   acknowledged with a one-cycle ready pulse (DONE).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        fetch request and address
//   i_rdata/i_ready     registered fetch data, completion pulse
//   d_read/d_write      load/store request (both high = store)
//   d_addr/d_wdata      data address and store data
//   d_rdata/d_ready     registered load data, completion pulse
//   mem_read/mem_write  memory strobes, high only in ACCESS
//   mem_addr            latched address during ACCESS, 0 otherwise
//   mem_data            bidirectional bus, driven only in ACCESS of a store
//   busy                high in ACCESS and DONE
module unified_mem_port #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2,
    parameter int ARB_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    inout  wire  [WORD_SIZE-1:0] mem_data,
    output logic                 busy
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic                 wr_q;      // latched op: 1 = store
    logic                 dch_q;     // granted channel: 1 = data
    logic                 last_q;    // channel granted last: 1 = data
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] i_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;

    logic d_req, any_req, grant_d, cnt_last, drive_en;

    assign d_req    = d_read | d_write;
    assign any_req  = i_req | d_req;
    assign cnt_last = (cnt_q == CNT_LAST);

    // Arbitration: data wins alone or under fixed priority; in round-robin
    // a conflict goes to whichever channel did not win the previous grant.
    always_comb begin
        grant_d = 1'b0;
        if (d_req) begin
            if (!i_req)
                grant_d = 1'b1;
            else if (ARB_MODE == 0)
                grant_d = 1'b1;
            else
                grant_d = !last_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch, latency counter and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            dch_q     <= 1'b0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        dch_q   <= grant_d;
                        last_q  <= grant_d;
                        wr_q    <= grant_d & d_write;  // store dominates a simultaneous load
                        addr_q  <= grant_d ? d_addr : i_addr;
                        wdata_q <= d_wdata;
                        cnt_q   <= '0;
                    end
                end
                S_ACCESS: begin
                    if (cnt_last) begin
                        if (!wr_q) begin
                            if (dch_q) d_rdata_q <= mem_data;
                            else       i_rdata_q <= mem_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        drive_en  = 1'b0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_ACCESS: begin
                busy      = 1'b1;
                mem_addr  = addr_q;
                mem_read  = !wr_q;
                mem_write = wr_q;
                drive_en  = wr_q;
            end
            S_DONE: begin
                busy    = 1'b1;
                i_ready = !dch_q;
                d_ready = dch_q;
            end
            default: ;
        endcase
    end

    assign mem_data = drive_en ? wdata_q : {WORD_SIZE{1'bz}};
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_port.sv
// Bench for unified_mem_port. Three instances cover the parameter points:
//   u0: LATENCY=2 fixed priority, u1: LATENCY=1 round-robin,
//   u2: LATENCY=4 fixed priority (reset-mid-access).
// A transaction model tracks cycles elapsed since each grant and derives
// the expected strobes, ready pulses and read data; directed literals pin
// latencies and data values.
module tb_unified_mem_port;

    localparam int LATS [3] = '{2, 1, 4};
    localparam int ARBS [3] = '{0, 1, 0};

    logic clk = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [2:0]  rst, i_req, d_read, d_write;
    logic [15:0] i_addr [3];
    logic [15:0] d_addr [3];
    logic [15:0] d_wdata [3];
    wire  [15:0] i_rdata [3];
    wire  [15:0] d_rdata [3];
    wire  [15:0] mem_addr [3];
    wire  [2:0]  i_ready, d_ready, mem_read, mem_write, busy;
    wire  [15:0] md0, md1, md2;

    logic [15:0] mem [3][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_port #(.WORD_SIZE(16), .LATENCY(2), .ARB_MODE(0)) u0 (
        .clk(clk), .reset(rst[0]), .i_req(i_req[0]), .i_addr(i_addr[0]),
        .i_rdata(i_rdata[0]), .i_ready(i_ready[0]), .d_read(d_read[0]),
        .d_write(d_write[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ready(d_ready[0]), .mem_read(mem_read[0]),
        .mem_write(mem_write[0]), .mem_addr(mem_addr[0]), .mem_data(md0),
        .busy(busy[0]));
    unified_mem_port #(.WORD_SIZE(16), .LATENCY(1), .ARB_MODE(1)) u1 (
        .clk(clk), .reset(rst[1]), .i_req(i_req[1]), .i_addr(i_addr[1]),
        .i_rdata(i_rdata[1]), .i_ready(i_ready[1]), .d_read(d_read[1]),
        .d_write(d_write[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ready(d_ready[1]), .mem_read(mem_read[1]),
        .mem_write(mem_write[1]), .mem_addr(mem_addr[1]), .mem_data(md1),
        .busy(busy[1]));
    unified_mem_port #(.WORD_SIZE(16), .LATENCY(4), .ARB_MODE(0)) u2 (
        .clk(clk), .reset(rst[2]), .i_req(i_req[2]), .i_addr(i_addr[2]),
        .i_rdata(i_rdata[2]), .i_ready(i_ready[2]), .d_read(d_read[2]),
        .d_write(d_write[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]),
        .d_rdata(d_rdata[2]), .d_ready(d_ready[2]), .mem_read(mem_read[2]),
        .mem_write(mem_write[2]), .mem_addr(mem_addr[2]), .mem_data(md2),
        .busy(busy[2]));

    // Memory side: answers reads combinationally, commits writes on the edge.
    // Buses are pulled low so a released bus reads as 0.
    assign md0 = mem_read[0] ? mem[0][mem_addr[0][7:0]] : 16'hzzzz;
    assign md1 = mem_read[1] ? mem[1][mem_addr[1][7:0]] : 16'hzzzz;
    assign md2 = mem_read[2] ? mem[2][mem_addr[2][7:0]] : 16'hzzzz;
    for (genvar b = 0; b < 16; b++) begin : g_pd
        pulldown (md0[b]);
        pulldown (md1[b]);
        pulldown (md2[b]);
    end

    always @(posedge clk) begin
        if (mem_write[0]) mem[0][mem_addr[0][7:0]] <= md0;
        if (mem_write[1]) mem[1][mem_addr[1][7:0]] <= md1;
        if (mem_write[2]) mem[2][mem_addr[2][7:0]] <= md2;
    end

    function automatic logic [15:0] md_of(input int k);
        case (k)
            0:       return md0;
            1:       return md1;
            default: return md2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // ph = cycles since grant: 0 idle, 1..L on the bus, L+1 ready cycle.
    int          ph    [3] = '{0, 0, 0};
    logic        mch   [3] = '{1'b0, 1'b0, 1'b0};
    logic        mwr   [3] = '{1'b0, 1'b0, 1'b0};
    logic        mlast [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] maddr [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] mwd   [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] mird  [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] mdrd  [3] = '{16'h0, 16'h0, 16'h0};

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            int          L;
            logic        gd, acc;
            logic [15:0] ebus;
            L = LATS[k];
            // advance with the inputs seen at this edge
            if (rst[k]) begin
                ph[k] = 0; mlast[k] = 1'b0; mird[k] = 16'h0; mdrd[k] = 16'h0;
            end else if (ph[k] == 0) begin
                if (i_req[k] | d_read[k] | d_write[k]) begin
                    gd = (d_read[k] | d_write[k]) &&
                         (!i_req[k] || ARBS[k] == 0 || !mlast[k]);
                    mch[k]   = gd;
                    mlast[k] = gd;
                    mwr[k]   = gd & d_write[k];
                    maddr[k] = gd ? d_addr[k] : i_addr[k];
                    mwd[k]   = d_wdata[k];
                    ph[k]    = 1;
                end
            end else if (ph[k] == L + 1) begin
                ph[k] = 0;
            end else begin
                if (ph[k] == L && !mwr[k]) begin
                    if (mch[k]) mdrd[k] = mem[k][maddr[k][7:0]];
                    else        mird[k] = mem[k][maddr[k][7:0]];
                end
                ph[k]++;
            end
            // compare
            acc  = (ph[k] >= 1) && (ph[k] <= L);
            ebus = (acc && mwr[k]) ? mwd[k] : (acc ? mem[k][maddr[k][7:0]] : 16'h0000);
            chk($sformatf("u%0d.mem_read", k),  16'(mem_read[k]),  16'(acc && !mwr[k]));
            chk($sformatf("u%0d.mem_write", k), 16'(mem_write[k]), 16'(acc && mwr[k]));
            chk($sformatf("u%0d.mem_data", k),  md_of(k), ebus);
            if (acc) chk($sformatf("u%0d.mem_addr", k), mem_addr[k], maddr[k]);
            chk($sformatf("u%0d.i_ready", k), 16'(i_ready[k]), 16'(ph[k] == L + 1 && !mch[k]));
            chk($sformatf("u%0d.d_ready", k), 16'(d_ready[k]), 16'(ph[k] == L + 1 && mch[k]));
            chk($sformatf("u%0d.busy", k),    16'(busy[k]),    16'(ph[k] != 0));
            chk($sformatf("u%0d.i_rdata", k), i_rdata[k], mird[k]);
            chk($sformatf("u%0d.d_rdata", k), d_rdata[k], mdrd[k]);
        end
    end

    // Wait for a ready pulse; dt = cycles from the request cycle t0.
    task automatic wait_rdy(input int k, input bit dch, input int t0, output int dt);
        dt = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((dch ? d_ready[k] : i_ready[k]) === 1'b1) begin
                dt = cyc - t0;
                break;
            end
        end
        if (dt < 0) begin
            checks++; errors++;
            $display("FAIL u%0d.ready_timeout dch=%0d got=none want=pulse", k, dch);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t0, dt, nr, ne;
        int  evc [4];
        bit  evd [4];
        rst = 3'b111; i_req = '0; d_read = '0; d_write = '0;
        for (int k = 0; k < 3; k++) begin
            i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
            for (int a = 0; a < 256; a++) mem[k][a] <= 16'(a) ^ 16'h0F00;
        end
        mem[0][8'h10] <= 16'h1234;
        mem[0][8'h20] <= 16'hCAFE;
        mem[1][8'h01] <= 16'hA001;
        mem[1][8'h02] <= 16'hD002;
        mem[2][8'h50] <= 16'h5A5A;
        repeat (2) @(negedge clk);
        chk("reset.busy",    16'(busy), 16'h0);
        chk("reset.i_rdata", i_rdata[0], 16'h0);
        chk("reset.d_rdata", d_rdata[0], 16'h0);
        chk("reset.bus",     md0, 16'h0);
        rst = 3'b000;
        @(negedge clk);

        // single fetch
        i_req[0] = 1'b1; i_addr[0] = 16'h0010; t0 = cyc;
        wait_rdy(0, 1'b0, t0, dt); i_req[0] = 1'b0;
        chk("fetch.lat",  16'(dt), 16'd3);
        chk("fetch.data", i_rdata[0], 16'h1234);
        repeat (2) @(negedge clk);

        // load to seed d_rdata
        d_read[0] = 1'b1; d_addr[0] = 16'h0020; t0 = cyc;
        wait_rdy(0, 1'b1, t0, dt); d_read[0] = 1'b0;
        chk("load.lat",  16'(dt), 16'd3);
        chk("load.data", d_rdata[0], 16'hCAFE);
        repeat (2) @(negedge clk);

        // store
        d_write[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'hBEEF; t0 = cyc;
        chk("store.bus_c0", md0, 16'h0);
        @(negedge clk);
        chk("store.bus_c1", md0, 16'hBEEF);
        chk("store.wr_c1",  16'(mem_write[0]), 16'h1);
        wait_rdy(0, 1'b1, t0, dt); d_write[0] = 1'b0;
        chk("store.lat",    16'(dt), 16'd3);
        chk("store.bus_c3", md0, 16'h0);
        chk("store.rdata",  d_rdata[0], 16'hCAFE);
        chk("store.mem",    mem[0][8'h40], 16'hBEEF);
        repeat (2) @(negedge clk);

        // read+write together behaves as a store
        d_read[0] = 1'b1; d_write[0] = 1'b1; d_addr[0] = 16'h0020; d_wdata[0] = 16'h1111;
        t0 = cyc;
        @(negedge clk);
        chk("rw.mem_read",  16'(mem_read[0]),  16'h0);
        chk("rw.mem_write", 16'(mem_write[0]), 16'h1);
        wait_rdy(0, 1'b1, t0, dt); d_read[0] = 1'b0; d_write[0] = 1'b0;
        chk("rw.lat",   16'(dt), 16'd3);
        chk("rw.rdata", d_rdata[0], 16'hCAFE);
        chk("rw.mem",   mem[0][8'h20], 16'h1111);
        repeat (2) @(negedge clk);

        // conflict, fixed priority: data first, fetch waits
        i_req[0] = 1'b1; i_addr[0] = 16'h0010;
        d_read[0] = 1'b1; d_addr[0] = 16'h0040; t0 = cyc;
        wait_rdy(0, 1'b1, t0, dt); d_read[0] = 1'b0;
        chk("conf0.d_lat", 16'(dt), 16'd3);
        chk("conf0.d_data", d_rdata[0], 16'hBEEF);
        wait_rdy(0, 1'b0, t0, dt); i_req[0] = 1'b0;
        chk("conf0.i_lat", 16'(dt), 16'd7);
        chk("conf0.i_data", i_rdata[0], 16'h1234);
        repeat (2) @(negedge clk);

        // conflict, round-robin, LATENCY=1, both held
        i_req[1] = 1'b1; i_addr[1] = 16'h0001;
        d_read[1] = 1'b1; d_addr[1] = 16'h0002; t0 = cyc; ne = 0;
        for (int n = 0; n < 30 && ne < 4; n++) begin
            @(negedge clk);
            if (d_ready[1] === 1'b1 || i_ready[1] === 1'b1) begin
                evc[ne] = cyc - t0; evd[ne] = d_ready[1]; ne++;
            end
        end
        i_req[1] = 1'b0; d_read[1] = 1'b0;
        chk("rr.count", 16'(ne), 16'd4);
        if (ne == 4) begin
            chk("rr.t0", 16'(evc[0]), 16'd2);  chk("rr.ch0", 16'(evd[0]), 16'h1);
            chk("rr.t1", 16'(evc[1]), 16'd5);  chk("rr.ch1", 16'(evd[1]), 16'h0);
            chk("rr.t2", 16'(evc[2]), 16'd8);  chk("rr.ch2", 16'(evd[2]), 16'h1);
            chk("rr.t3", 16'(evc[3]), 16'd11); chk("rr.ch3", 16'(evd[3]), 16'h0);
        end
        chk("rr.i_data", i_rdata[1], 16'hA001);
        chk("rr.d_data", d_rdata[1], 16'hD002);
        repeat (2) @(negedge clk);

        // reset in cycle 2 of a LATENCY=4 store, request held through reset
        d_write[2] = 1'b1; d_addr[2] = 16'h0060; d_wdata[2] = 16'h7777; t0 = cyc;
        repeat (2) @(negedge clk);
        chk("rst.wr_c2",  16'(mem_write[2]), 16'h1);
        chk("rst.bus_c2", md2, 16'h7777);
        rst[2] = 1'b1;
        @(negedge clk);
        chk("rst.wr_c3",  16'(mem_write[2]), 16'h0);
        chk("rst.bus_c3", md2, 16'h0);
        chk("rst.busy_c3", 16'(busy[2]), 16'h0);
        @(negedge clk);
        chk("rst.nogrant", 16'(busy[2]), 16'h0);
        rst[2] = 1'b0; d_write[2] = 1'b0;
        nr = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (d_ready[2] === 1'b1) nr++;
        end
        chk("rst.no_ready", 16'(nr), 16'd0);
        d_read[2] = 1'b1; d_addr[2] = 16'h0050; t0 = cyc;
        wait_rdy(2, 1'b1, t0, dt); d_read[2] = 1'b0;
        chk("rst.reload_lat",  16'(dt), 16'd5);
        chk("rst.reload_data", d_rdata[2], 16'h5A5A);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_port.md
# unified_mem_port

Single-port memory access unit that lets the pipeline's instruction-fetch and data-access channels share one external memory port, which has a fixed multi-cycle latency. It sits between the IF/MEM stages and the external memory bus. It arbitrates between the two channels, latches the winning request, and drives the memory control lines and the bidirectional data bus for the configured latency. It returns read data with a one-cycle ready pulse so the hazard unit can stall on a low ready.

## Interface
Parameters:
- WORD_SIZE, default 16, width of addresses and data words.
- LATENCY, default 2, number of cycles the memory request is held on the bus; legal range ≥1.
- ARB_MODE, default 0. 0 = fixed priority, data channel wins. 1 = round-robin, alternating on conflict.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request.
- i_addr  in  WORD_SIZE  fetch address.
- i_rdata  out  WORD_SIZE  fetched instruction, registered.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- d_read  in  1  data load request.
- d_write  in  1  data store request.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  store data.
- d_rdata  out  WORD_SIZE  load data, registered.
- d_ready  out  1  one-cycle pulse: load/store complete.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  WORD_SIZE  memory address.
- mem_data  inout  WORD_SIZE  bidirectional data bus; high-Z unless a write is in ACCESS.
- busy  out  1  high while a granted access is in flight (ACCESS or DONE).

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - If any request is present, grant one channel and latch op, address and wdata into internal registers. Go to ACCESS with cnt=0.
  - With no request, stay in IDLE.
- Data request definition: d_read|d_write. If both are high, the access is a write and the read is ignored.
- Conflict (instruction and data requests in the same IDLE cycle):
  - ARB_MODE=0: data is granted.
  - ARB_MODE=1: the channel not granted last is granted. last_grant resets to instruction, so the first conflict goes to data.
  - last_grant updates on every grant, conflicting or not.
- ACCESS:
  - mem_addr is driven from the latched address.
  - mem_read=1 for reads; mem_write=1 for writes, with mem_data driven from the latched wdata.
  - cnt increments each cycle. When cnt==LATENCY-1: a read captures mem_data into the granted channel's rdata register, and the FSM goes to DONE.
- DONE:
  - Strobes are low and the bus is high-Z.
  - The granted channel's ready is high for this single cycle.
  - The FSM goes to IDLE unconditionally.
- Requester rule: hold req and operands stable until the cycle ready is seen. Drop or change them in the following cycle. Operand changes after grant have no effect.
- i_rdata and d_rdata hold their values until the next completed read on the same channel. A store does not modify d_rdata.
- Arithmetic: cnt is wide enough for LATENCY-1 and never wraps; it is cleared on entry to ACCESS.

## Timing
- A request visible in IDLE at cycle 0 produces:
  - strobes in cycles 1..LATENCY;
  - ready in cycle LATENCY+1;
  - return to IDLE at cycle LATENCY+2.
- Minimum spacing between back-to-back accesses is LATENCY+2 cycles.
- A request arriving while busy is not granted until IDLE. Its requester observes ready low, which is the stall indication.
- mem_data is driven only in ACCESS cycles of a write. It is released in the same edge that leaves ACCESS, so there is no overlap with DONE.
- Reset values: state IDLE; cnt 0; mem_read 0; mem_write 0; mem_addr 0; mem_data high-Z; i_ready 0; d_ready 0; i_rdata 0; d_rdata 0; busy 0; last_grant instruction.
- Reset mid-access:
  - The access aborts at that edge. Strobes go low, the bus is released, and no ready pulse is produced.
  - A write in flight is not guaranteed to have committed to memory.
- Simultaneous request and reset: reset wins, and there is no grant that cycle.

## Test plan
- Single fetch, LATENCY=2: i_req=1, i_addr=0x0010, memory returns 0x1234 → mem_read high in cycles 1-2, i_ready pulse at cycle 3, i_rdata=0x1234, d_ready stays 0.
- Store: d_write=1, d_addr=0x0040, d_wdata=0xBEEF → mem_write=1 and mem_data=0xBEEF in cycles 1-2, high-Z in cycle 0 and from cycle 3; d_ready at cycle 3; d_rdata unchanged.
- Conflict, ARB_MODE=0: i_req and d_read both held → data ready at cycle 3, instruction granted at cycle 4, i_ready at cycle 7.
- Conflict, ARB_MODE=1, both requests held continuously:
  - Grants alternate data, instr, data, instr…
  - With LATENCY=1, ready pulses land at cycles 2 (d), 5 (i), 8 (d), 11 (i).
- Reset at cycle 2 of a LATENCY=4 write → strobes 0 and bus high-Z from cycle 3, no d_ready ever; a new d_read after reset completes normally.
- d_read and d_write both high → treated as a write: mem_write=1, mem_read=0, d_rdata unchanged.
